// File: rtl/ip_payload_dispatcher.sv
// ip_payload_dispatcher
// Routes each IP payload to the downstream protocol decoder whose protocol
// number matches the IP protocol field. Payload words go through a shared
// show-ahead FIFO with per-channel valid/ready handshake. Packets whose
// protocol matches no channel are discarded and counted (saturating).
// The packet result combines the IP decoder status with the selected channel.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   data_in, wr_en      payload word and strobe from the IP decoder
//   len_in, protocol    packet length (bytes) / protocol, valid on first wr_en
//   ok_ip, fin_ip       IP decoder status / completion
//   ch_data, ch_len     shared payload bus and latched packet length
//   ch_start            one-cycle one-hot start pulse on the first word
//   ch_valid, ch_ready  per-channel word handshake (one-hot valid)
//   ch_ok, ch_fin       per-channel decoder status / completion
//   ok, fin             packet result (ok valid while fin=1)
//   busy                controller not idle
//   overflow            sticky FIFO overflow / upstream violation flag
//   drop_cnt            saturating count of unmatched packets
//
// state | meaning
// IDLE  | no packet seen since reset
// FWD   | receiving words of a matched packet into the FIFO
// DROP  | receiving and discarding words of an unmatched packet
// DRAIN | all words received, waiting for the FIFO to empty
// WAIT  | waiting for fin_ip and the selected channel's fin
// DONE  | result presented; a new first word starts the next packet
module ip_payload_dispatcher #(
  parameter int                  DATA_W    = 32,
  parameter int                  NUM_CH    = 2,
  parameter logic [NUM_CH*8-1:0] PROTO_MAP = {8'd17, 8'd6},
  parameter int                  DEPTH     = 8,
  parameter int                  CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [15:0]       len_in,
  input  logic [7:0]        protocol,
  input  logic              wr_en,
  input  logic              ok_ip,
  input  logic              fin_ip,
  output logic [DATA_W-1:0] ch_data,
  output logic [15:0]       ch_len,
  output logic [NUM_CH-1:0] ch_start,
  output logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_ok,
  input  logic [NUM_CH-1:0] ch_fin,
  output logic              ok,
  output logic              fin,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_DROP, S_DRAIN, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        words_q, words_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               fin_q, fin_d, ok_q, ok_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               hit;
  logic [SEL_W-1:0]   hit_sel;
  logic [15:0]        w_calc, w_first;
  logic               empty, full, fwd_active, pop, push, do_write, start_pulse;

  // Lowest matching channel wins: scan downwards so the last hit is the lowest.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (PROTO_MAP[8*i +: 8] == protocol) begin
        hit     = 1'b1;
        hit_sel = SEL_W'(i);
      end
    end
  end

  // A zero-length payload still carries one word.
  assign w_calc  = 16'((32'(len_in) + BYTES - 1) / BYTES);
  assign w_first = (w_calc == 16'd0) ? 16'd1 : w_calc;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fwd_active = (state_q == S_FWD) || (state_q == S_DRAIN);
  assign pop        = fwd_active && !empty && ch_ready[sel_q];

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    len_d       = len_q;
    words_d     = words_q;
    cnt_d       = cnt_q;
    fin_d       = fin_q;
    ok_d        = ok_q;
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    push        = 1'b0;
    start_pulse = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (wr_en) begin
          len_d   = len_in;
          words_d = w_first;
          cnt_d   = 16'd1;
          fin_d   = 1'b0;
          ok_d    = 1'b0;
          ovf_d   = 1'b0;
          if (hit) begin
            sel_d       = hit_sel;
            push        = 1'b1;
            start_pulse = 1'b1;
            state_d     = (w_first == 16'd1) ? S_DRAIN : S_FWD;
          end else begin
            sel_d = '0;
            if (w_first == 16'd1) begin
              if (drop_q != '1) drop_d = drop_q + 1'b1;
              fin_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end
      S_FWD: begin
        if (wr_en) begin
          push  = 1'b1;
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == words_q) state_d = S_DRAIN;
        end
      end
      S_DROP: begin
        if (wr_en) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == words_q) begin
            if (drop_q != '1) drop_d = drop_q + 1'b1;
            fin_d   = 1'b1;
            ok_d    = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DRAIN: begin
        if (wr_en) ovf_d = 1'b1;
        if (empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wr_en) ovf_d = 1'b1;
        if (ch_fin[sel_q] && fin_ip) begin
          fin_d   = 1'b1;
          ok_d    = ok_ip & ch_ok[sel_q] & ~ovf_d;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A push into a full FIFO only survives if a pop frees a slot this cycle.
    do_write = push;
    if (push && full && !pop) begin
      do_write = 1'b0;
      ovf_d    = 1'b1;
    end
    wr_ptr_d = do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      len_q    <= '0;
      words_q  <= '0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      ok_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      words_q  <= words_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      ok_q     <= ok_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_write) mem[wr_ptr_q[AW-1:0]] <= data_in;
  end

  // Bus reads as zero while empty so nothing stale shows after reset.
  assign ch_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign ch_len   = len_q;
  assign ch_start = (start_pulse && reset) ? (NUM_CH'(1) << hit_sel) : '0;
  assign ch_valid = (fwd_active && !empty) ? (NUM_CH'(1) << sel_q) : '0;
  assign ok       = ok_q;
  assign fin      = fin_q;
  assign busy     = (state_q != S_IDLE);
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_ip_payload_dispatcher.sv
// Testbench for ip_payload_dispatcher: directed scenarios followed by a
// randomized packet stream, checked by a scoreboard-driven monitor.
module tb_ip_payload_dispatcher;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int DC_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic [15:0]       len_in;
  logic [7:0]        protocol;
  logic              wr_en, ok_ip, fin_ip;
  logic [DATA_W-1:0] ch_data;
  logic [15:0]       ch_len;
  logic [NUM_CH-1:0] ch_start, ch_valid, ch_ready, ch_ok, ch_fin;
  logic              ok, fin, busy, overflow;
  logic [CNT_W-1:0]  drop_cnt;

  always #5 clk = ~clk;

  ip_payload_dispatcher #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .PROTO_MAP({8'd17, 8'd6}),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .len_in(len_in),
    .protocol(protocol), .wr_en(wr_en), .ok_ip(ok_ip), .fin_ip(fin_ip),
    .ch_data(ch_data), .ch_len(ch_len), .ch_start(ch_start),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_ok(ch_ok), .ch_fin(ch_fin),
    .ok(ok), .fin(fin), .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct { int ch; logic [DATA_W-1:0] data; } word_t;
  typedef struct { logic ok; logic ovf; logic [CNT_W-1:0] dc; logic [15:0] len; } res_t;

  logic [7:0] proto_tab [NUM_CH] = '{8'd6, 8'd17};

  word_t exp_data[$];
  int    exp_start[$];
  res_t  exp_res[$];
  int    errors = 0, checks = 0;
  int    pushes = 0, pops = 0, dc_model = 0;

  logic              rand_ready = 1'b0;
  logic [NUM_CH-1:0] ready_force = '0, rnd_ready = '0;
  assign ch_ready = rand_ready ? rnd_ready : ready_force;

  always @(posedge clk) begin
    #1;
    rnd_ready = NUM_CH'($urandom);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every start pulse, every accepted word and every
  // packet completion against the heads of the scoreboard queues.
  logic  prev_fin = 1'b0, prev_wr = 1'b0;
  int    mc;
  word_t mw;
  res_t  mr;
  always @(negedge clk) begin
    if (ch_start != '0) begin
      if (exp_start.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected ch_start: got %0h expected none", ch_start);
      end else begin
        mc = exp_start.pop_front();
        check("ch_start", 64'(ch_start), 64'(1 << mc));
      end
    end
    if ((ch_valid & ch_ready) != '0) begin
      pops++;
      if (exp_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected word: got valid=%0h data=%0h expected none", ch_valid, ch_data);
      end else begin
        mw = exp_data.pop_front();
        check("ch_valid", 64'(ch_valid), 64'(1 << mw.ch));
        check("ch_data", 64'(ch_data), 64'(mw.data));
      end
    end
    // A single-word drop started in DONE finishes without fin dropping.
    if (fin && (!prev_fin || prev_wr)) begin
      if (exp_res.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected fin: got fin=1 expected none");
      end else begin
        mr = exp_res.pop_front();
        check("ok", 64'(ok), 64'(mr.ok));
        check("overflow", 64'(overflow), 64'(mr.ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(mr.dc));
        check("ch_len", 64'(ch_len), 64'(mr.len));
      end
    end
    prev_fin = fin;
    prev_wr  = wr_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one packet. keep_n: words expected to reach the channel;
  // ready_at: word index at which ready_force goes high (>= words: after the
  // last word); b2b_next: return in the DONE cycle so the next packet starts there.
  task automatic send_pkt(input logic [7:0] proto, input logic [15:0] len,
                          input bit throttle, input int keep_n, input bit extra_wr,
                          input int ready_at, input bit b2b_next, input bit rnd_ok);
    int nw, ch, bound;
    logic oki;
    logic [NUM_CH-1:0] chok;
    bit ovf;
    res_t r;
    word_t w;
    logic [DATA_W-1:0] d;
    nw = (len == 16'd0) ? 1 : (int'(len) + DATA_W/8 - 1) / (DATA_W/8);
    ch = -1;
    for (int i = 0; i < NUM_CH; i++) if (ch < 0 && proto_tab[i] == proto) ch = i;
    oki  = rnd_ok ? ($urandom_range(0, 4) != 0) : 1'b1;
    chok = rnd_ok ? NUM_CH'($urandom | $urandom) : '1;
    ovf  = extra_wr || (keep_n < nw);
    if (ch >= 0) begin
      r.ok  = oki & chok[ch] & ~ovf;
      r.ovf = ovf;
      exp_start.push_back(ch);
    end else begin
      r.ok  = 1'b0;
      r.ovf = 1'b0;
      if (dc_model < DC_MAX) dc_model++;
    end
    r.dc  = CNT_W'(dc_model);
    r.len = len;
    exp_res.push_back(r);
    ok_ip = oki;
    ch_ok = chok;
    len_in = len;
    protocol = proto;
    for (int k = 0; k < nw; k++) begin
      if (ready_at == k) ready_force = '1;
      if (throttle && ch >= 0) begin
        bound = 0;
        while (pushes - pops >= DEPTH && bound < 200) begin
          tick();
          bound++;
        end
        if (bound >= 200) begin
          checks++; errors++;
          $display("FAIL fifo drain timeout: got occupancy %0d expected below %0d", pushes - pops, DEPTH);
        end
      end
      d = DATA_W'($urandom);
      data_in = d;
      wr_en = 1'b1;
      if (ch >= 0 && k < keep_n) begin
        w.ch = ch;
        w.data = d;
        exp_data.push_back(w);
        pushes++;
      end
      tick();
      wr_en = 1'b0;
      if (throttle && k < nw - 1 && $urandom_range(0, 3) == 0) tick();
    end
    if (extra_wr) begin
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
    end
    if (ready_at >= nw) begin
      repeat (3) tick();
      ready_force = '1;
    end
    repeat ($urandom_range(0, 3)) tick();
    fin_ip = 1'b1;
    ch_fin = '1;
    bound = 0;
    while (!fin && bound < 300) begin
      tick();
      bound++;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL fin timeout: got fin=0 expected 1 (proto %0d len %0d)", proto, len);
    end
    fin_ip = 1'b0;
    ch_fin = '0;
    if (!b2b_next) repeat ($urandom_range(1, 3)) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; data_in = '0; len_in = '0; protocol = '0; wr_en = 1'b0;
    ok_ip = 1'b0; fin_ip = 1'b0; ch_ok = '0; ch_fin = '0;
    repeat (3) tick();
    check("rst busy", 64'(busy), 0);
    check("rst fin", 64'(fin), 0);
    check("rst ok", 64'(ok), 0);
    check("rst overflow", 64'(overflow), 0);
    check("rst drop_cnt", 64'(drop_cnt), 0);
    check("rst ch_valid", 64'(ch_valid), 0);
    check("rst ch_len", 64'(ch_len), 0);
    reset = 1'b1;
    tick();

    // Basic forward to channel 0, 3 words.
    ready_force = '1;
    send_pkt(8'd6, 16'd12, 1'b0, 99, 1'b0, -1, 1'b0, 1'b0);
    // Channel 1 held off, 2 words buffered then released.
    ready_force = 2'b01;
    send_pkt(8'd17, 16'd5, 1'b0, 99, 1'b0, 2, 1'b0, 1'b0);
    // Unmatched protocol dropped.
    send_pkt(8'd1, 16'd8, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0);
    // Zero length still carries one word.
    send_pkt(8'd17, 16'd0, 1'b0, 99, 1'b0, -1, 1'b0, 1'b0);
    // Extra word after the last one: violation flagged, result forced bad.
    send_pkt(8'd6, 16'd4, 1'b0, 99, 1'b1, -1, 1'b0, 1'b0);
    // Overflow: nothing accepted, 6 words into a 4-deep FIFO.
    ready_force = '0;
    send_pkt(8'd6, 16'd24, 1'b0, DEPTH, 1'b0, 6, 1'b1, 1'b0);
    // Push and pop together while full: no loss; back-to-back start.
    ready_force = '0;
    send_pkt(8'd6, 16'd20, 1'b0, 99, 1'b0, 4, 1'b1, 1'b0);
    send_pkt(8'd17, 16'd8, 1'b0, 99, 1'b0, -1, 1'b0, 1'b0);
    // Drop counter saturation.
    for (int i = 0; i < DC_MAX + 1; i++)
      send_pkt(8'd99, 16'(4 * $urandom_range(0, 2)), 1'b0, 0, 1'b0, -1, 1'b0, 1'b0);

    // Reset in FWD with 2 words buffered.
    ready_force = '0;
    exp_start.push_back(0);
    len_in = 16'd12; protocol = 8'd6;
    data_in = 32'h1111; wr_en = 1'b1; tick();
    data_in = 32'h2222; tick();
    wr_en = 1'b0; reset = 1'b0; tick();
    check("mid-rst busy", 64'(busy), 0);
    check("mid-rst ch_valid", 64'(ch_valid), 0);
    check("mid-rst ch_data", 64'(ch_data), 0);
    check("mid-rst fin", 64'(fin), 0);
    check("mid-rst drop_cnt", 64'(drop_cnt), 0);
    check("mid-rst ch_len", 64'(ch_len), 0);
    reset = 1'b1;
    pushes = 0; pops = 0; dc_model = 0;
    tick();
    ready_force = '1;
    send_pkt(8'd6, 16'd7, 1'b0, 99, 1'b0, -1, 1'b0, 1'b0);

    // Randomized stream with random backpressure and status.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [7:0] p;
      case ($urandom_range(0, 2))
        0: p = 8'd6;
        1: p = 8'd17;
        default: p = 8'($urandom_range(0, 255));
      endcase
      send_pkt(p, 16'($urandom_range(0, 36)), 1'b1, 1000, 1'b0, -1,
               bit'($urandom_range(0, 1)), 1'b1);
    end
    rand_ready = 1'b0;
    ready_force = '1;
    repeat (10) tick();
    check("words left", 64'(exp_data.size()), 0);
    check("starts left", 64'(exp_start.size()), 0);
    check("results left", 64'(exp_res.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ip_payload_dispatcher.md
Name: ip_payload_dispatcher

Overview:
Parametrised successor to the fixed IP→TCP/UDP fan-out. It sits between IP_decoder and NUM_CH protocol decoders and routes each IP payload to the channel whose protocol number matches. Payload words are buffered in a shared FIFO with per-channel valid/ready backpressure. The block drops and counts unmatched protocols, and aggregates ok/fin from IP and the selected channel.

Parameters:
DATA_W, 32, payload word width in bits; multiple of 8.
NUM_CH, 2, number of downstream protocol channels (1..8).
PROTO_MAP, {8'd17,8'd6}, NUM_CH×8 flattened table; bits [8i+7:8i] hold the protocol number for channel i.
DEPTH, 8, FIFO depth in words; power of 2, ≥2.
CNT_W, 16, width of the drop counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
data_in  in  DATA_W  payload word from IP decoder
len_in  in  16  payload length in bytes, valid with the first wr_en of a packet
protocol  in  8  IP protocol field, valid with the first wr_en
wr_en  in  1  payload word strobe
ok_ip  in  1  IP header/checksum ok
fin_ip  in  1  IP decode finished
ch_data  out  DATA_W  shared payload bus to all channels
ch_len  out  16  latched len_in for the current packet
ch_start  out  NUM_CH  one-cycle start pulse, one-hot
ch_valid  out  NUM_CH  word valid, one-hot on the selected channel
ch_ready  in  NUM_CH  per-channel accept
ch_ok  in  NUM_CH  per-channel decode ok
ch_fin  in  NUM_CH  per-channel decode finished
ok  out  1  packet result, valid when fin=1
fin  out  1  packet complete
busy  out  1  state≠IDLE
overflow  out  1  sticky FIFO overflow, cleared on next packet start
drop_cnt  out  CNT_W  count of dropped packets, saturating

Behaviour:
- Reset (reset=0 at a clk edge) drives: all outputs 0, FIFO empty, state IDLE, sel=0, word counter 0, drop_cnt 0. Applies mid-packet; any in-flight packet is discarded with no fin.
- Words per packet: W = max(1, ceil(len_in/(DATA_W/8))), computed from len_in latched on the first wr_en.
- Lookup: lowest channel index i with PROTO_MAP[i]==protocol. No match → DROP.
- FSM:
  - IDLE: on wr_en, latch len/protocol/sel, clear fin/ok/overflow, count word 1. Go to FWD (store word, pulse ch_start[sel] the same cycle) or DROP (discard). If W==1, FWD goes to DRAIN and DROP goes to DONE.
  - FWD: each wr_en stores a word and increments the counter; on the W-th word go to DRAIN.
  - DROP: count and discard words; after the W-th word, drop_cnt+1 (saturating at all-ones), go to DONE with ok=0.
  - DRAIN: wait for FIFO empty, then go to WAIT.
  - WAIT: wait for ch_fin[sel] and fin_ip, then go to DONE with ok = ok_ip & ch_ok[sel] & ~overflow.
  - DONE: fin=1, ok held. On next wr_en, behave as IDLE in the same cycle (back-to-back packets).
- FIFO: show-ahead. ch_data = mem[rd_ptr]; a word written at cycle t is visible at t+1. ch_valid[sel] = ~empty while in FWD/DRAIN; other bits stay 0. Pop when ch_valid[sel]&ch_ready[sel]. Pointers are log2(DEPTH)+1 bits and wrap.
- Simultaneous push/pop with FIFO full is legal: both occur, count unchanged.
- Push while full with no pop: word lost, overflow=1, packet ok forced 0, word counter still advances.
- wr_en in DRAIN/WAIT is an upstream protocol violation: ignored, overflow=1.
- ch_len holds its value until the next packet start.

Test Plan:
1. NUM_CH=2, protocol=6, len_in=12, 3 words 0xA,0xB,0xC, ch_ready=2'b11, ch_fin/ok[0]=1, fin_ip/ok_ip=1 → ch_start=01 on word 1; ch_data A,B,C with ch_valid=01; fin=1, ok=1; drop_cnt=0.
2. protocol=17, len_in=5, ch_ready[1] low for 4 cycles → 2 words buffered; released after ready rises; ch_valid=10; no loss; fin=1 after ch_fin[1].
3. protocol=1, len_in=8 → no ch_start or ch_valid; drop_cnt=1; fin=1, ok=0. Repeat with drop_cnt preset near all-ones → saturates.
4. DEPTH=4, ch_ready=0, 6 words → overflow=1, ok=0 at fin; with a pop in the same cycle as a push while full, no overflow.
5. Reset asserted in FWD with 2 words buffered → next cycle all outputs 0, FIFO empty; next packet processes normally.
6. Back-to-back packets (wr_en of the new packet in the DONE cycle) with protocols 6 then 17 → second ch_start=10 in that cycle, overflow cleared, results independent.
